// File: rtl/session_tx_scheduler.sv
// Session-layer tx scheduler: turns rx events and session timers into pending admin
// requests, arbitrates them with application traffic onto one composer, owns MsgSeqNum.
module session_tx_scheduler #(
    parameter int HB_CYCLES     = 1000,
    parameter int COUNTER_DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_new_msg_i,
    input  logic [2:0]               rx_error_i,
    input  logic [3:0]               rx_type_i,
    input  logic                     app_req_i,
    output logic                     app_gnt_o,
    output logic                     tx_start_o,
    output logic [3:0]               tx_type_o,
    output logic [COUNTER_DEPTH-1:0] tx_seqnum_o,
    input  logic                     tx_done_i,
    output logic                     session_active_o
);
    localparam logic [3:0] T_LOGON   = 4'd1;
    localparam logic [3:0] T_LOGOUT  = 4'd2;
    localparam logic [3:0] T_HB      = 4'd3;
    localparam logic [3:0] T_TESTREQ = 4'd4;
    localparam logic [3:0] T_RESEND  = 4'd5;
    localparam logic [3:0] T_REJECT  = 4'd6;
    localparam logic [3:0] T_APP     = 4'd8;

    localparam int P_LOGOUT  = 0;
    localparam int P_REJECT  = 1;
    localparam int P_RESEND  = 2;
    localparam int P_LOGON   = 3;
    localparam int P_TESTREQ = 4;
    localparam int P_HB      = 5;

    localparam int HBW = $clog2(HB_CYCLES);
    localparam int RXW = $clog2(3 * HB_CYCLES + 2);
    localparam logic [HBW-1:0] HB_LAST    = HBW'(HB_CYCLES - 1);
    localparam logic [RXW-1:0] RX_TESTREQ = RXW'(2 * HB_CYCLES);
    localparam logic [RXW-1:0] RX_LOGOUT  = RXW'(3 * HB_CYCLES);
    localparam logic [COUNTER_DEPTH-1:0] SEQ_ONE = COUNTER_DEPTH'(1);

    typedef enum logic [1:0] {SESS_DOWN = 2'd0, SESS_ACTIVE = 2'd1, SESS_CLOSING = 2'd2} sess_t;
    typedef enum logic {TX_IDLE = 1'b0, TX_WAIT = 1'b1} tx_state_t;

    sess_t                    sess;
    tx_state_t                tx_state, tx_state_next;
    logic [5:0]               pend, pend_set, pend_clr;
    logic [3:0]               win_type, type_q;
    logic                     grant, active, rx_ok, rx_clean, hb_fire, done_ev, logout_done;
    logic [HBW-1:0]           hb_cnt;
    logic [RXW-1:0]           rx_cnt;
    logic [COUNTER_DEPTH-1:0] seq;

    assign active      = (sess == SESS_ACTIVE);
    assign rx_ok       = rx_new_msg_i && (sess != SESS_DOWN);
    assign rx_clean    = rx_new_msg_i && (rx_error_i == 3'd0);
    assign done_ev     = (tx_state == TX_WAIT) && tx_done_i;
    assign logout_done = done_ev && (type_q == T_LOGOUT);
    // A start resets the heartbeat interval, so it pre-empts the timer firing.
    assign hb_fire     = active && !grant && (hb_cnt == HB_LAST);

    always_comb begin
        pend_set = '0;
        pend_set[P_LOGOUT]  = (rx_ok && (rx_error_i == 3'd2 || rx_error_i == 3'd4))
                            || (rx_clean && active && rx_type_i == T_LOGOUT)
                            || (active && rx_cnt == RX_LOGOUT);
        pend_set[P_REJECT]  = rx_ok && (rx_error_i == 3'd3 || rx_error_i == 3'd5);
        pend_set[P_RESEND]  = rx_ok && (rx_error_i == 3'd6);
        pend_set[P_LOGON]   = rx_clean && (sess == SESS_DOWN) && rx_type_i == T_LOGON;
        pend_set[P_TESTREQ] = active && (rx_cnt == RX_TESTREQ);
        pend_set[P_HB]      = (rx_clean && active && rx_type_i == T_TESTREQ) || hb_fire;
    end

    // Fixed-priority arbitration; only logout and logon may go out outside ACTIVE.
    always_comb begin
        grant    = 1'b0;
        win_type = 4'd0;
        pend_clr = '0;
        if (tx_state == TX_IDLE) begin
            grant = 1'b1;
            if (pend[P_LOGOUT]) begin
                win_type = T_LOGOUT;  pend_clr[P_LOGOUT] = 1'b1;
            end else if (pend[P_REJECT] && active) begin
                win_type = T_REJECT;  pend_clr[P_REJECT] = 1'b1;
            end else if (pend[P_RESEND] && active) begin
                win_type = T_RESEND;  pend_clr[P_RESEND] = 1'b1;
            end else if (pend[P_LOGON]) begin
                win_type = T_LOGON;   pend_clr[P_LOGON] = 1'b1;
            end else if (pend[P_TESTREQ] && active) begin
                win_type = T_TESTREQ; pend_clr[P_TESTREQ] = 1'b1;
            end else if (pend[P_HB] && active) begin
                win_type = T_HB;      pend_clr[P_HB] = 1'b1;
            end else if (active && app_req_i) begin
                win_type = T_APP;
            end else begin
                grant = 1'b0;
            end
        end
    end

    always_comb begin
        tx_state_next = tx_state;
        case (tx_state)
            TX_IDLE: if (grant) tx_state_next = TX_WAIT;
            TX_WAIT: if (tx_done_i) tx_state_next = TX_IDLE;
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sess   <= SESS_DOWN;
            pend   <= '0;
            type_q <= 4'd0;
            seq    <= SEQ_ONE;
            hb_cnt <= '0;
            rx_cnt <= '0;
        end else begin
            if (grant) type_q <= win_type;
            // Set beats a same-cycle grant clear; a finished logout wipes everything.
            pend <= logout_done ? '0 : ((pend & ~pend_clr) | pend_set);

            if (logout_done)             sess <= SESS_DOWN;
            else if (pend_set[P_LOGOUT]) sess <= SESS_CLOSING;
            else if (done_ev && type_q == T_LOGON) sess <= SESS_ACTIVE;

            if (logout_done)  seq <= SEQ_ONE;
            else if (done_ev) seq <= (seq == '1) ? SEQ_ONE : seq + SEQ_ONE;

            if (!active || grant || hb_cnt == HB_LAST) hb_cnt <= '0;
            else                                       hb_cnt <= hb_cnt + HBW'(1);

            if (!active || rx_new_msg_i) rx_cnt <= '0;
            else                         rx_cnt <= rx_cnt + RXW'(1);
        end
    end

    assign tx_start_o       = grant;
    assign app_gnt_o        = grant && (win_type == T_APP);
    assign tx_type_o        = grant ? win_type : type_q;
    assign tx_seqnum_o      = seq;
    assign session_active_o = active;
endmodule

// File: tb/tb_session_tx_scheduler.sv
// Directed bench for session_tx_scheduler: HB_CYCLES=8, COUNTER_DEPTH=4, composer
// modelled by tasks that answer tx_start_o with tx_done_i one cycle later.
module tb_session_tx_scheduler;
    localparam int HB = 8;
    localparam int CD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_new_msg_i = 1'b0;
    logic [2:0]    rx_error_i = 3'd0;
    logic [3:0]    rx_type_i = 4'd0;
    logic          app_req_i = 1'b0;
    logic          app_gnt_o, tx_start_o, session_active_o;
    logic [3:0]    tx_type_o;
    logic [CD-1:0] tx_seqnum_o;
    logic          tx_done_i = 1'b0;

    session_tx_scheduler #(.HB_CYCLES(HB), .COUNTER_DEPTH(CD)) dut (
        .clk(clk), .rst(rst), .rx_new_msg_i(rx_new_msg_i), .rx_error_i(rx_error_i),
        .rx_type_i(rx_type_i), .app_req_i(app_req_i), .app_gnt_o(app_gnt_o),
        .tx_start_o(tx_start_o), .tx_type_o(tx_type_o), .tx_seqnum_o(tx_seqnum_o),
        .tx_done_i(tx_done_i), .session_active_o(session_active_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int gnt_cnt = 0;
    logic auto_done = 1'b0;
    logic keepalive = 1'b0;
    logic last_start = 1'b0;
    int         st_cyc[$];
    logic [3:0] st_type[$];
    logic [3:0] st_seq[$];
    logic       st_gnt[$];
    logic [3:0] exp_q[$];

    // Sample on the falling edge, then drive default inputs just after the rising edge.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        last_start = tx_start_o;
        if (tx_start_o) begin
            st_cyc.push_back(cyc);
            st_type.push_back(tx_type_o);
            st_seq.push_back(tx_seqnum_o);
            st_gnt.push_back(app_gnt_o);
        end
        if (app_gnt_o) gnt_cnt++;
        @(posedge clk);
        #1;
        rx_new_msg_i = keepalive && (cyc % 8 == 0);
        rx_error_i   = 3'd0;
        rx_type_i    = 4'd8;
        tx_done_i    = auto_done && last_start;
    endtask

    task automatic send_rx(input logic [2:0] err, input logic [3:0] typ);
        rx_new_msg_i = 1'b1;
        rx_error_i   = err;
        rx_type_i    = typ;
        cycle();
    endtask

    task automatic clear_log();
        st_cyc.delete(); st_type.delete(); st_seq.delete(); st_gnt.delete();
        gnt_cnt = 0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string name);
        int k = 0;
        while (st_type.size() < n && k < budget) begin
            cycle();
            k++;
        end
        n_checks++;
        if (st_type.size() < n) $display("FAIL %s timeout: got %0d starts, want %0d", name, st_type.size(), n);
        else n_pass++;
    endtask

    task automatic do_reset();
        rst = 1'b1; app_req_i = 1'b0; auto_done = 1'b0; keepalive = 1'b0; tx_done_i = 1'b0;
        repeat (3) cycle();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic bring_up();
        do_reset();
        auto_done = 1'b1;
        send_rx(3'd0, 4'd1);
        wait_starts(1, 10, "bring_up_logon");
        cycle();
        clear_log();
    endtask

    task automatic test_reset();
        rst = 1'b1; app_req_i = 1'b1;
        repeat (2) cycle();
        n_checks++; if (tx_start_o !== 1'b0) $display("FAIL rst_start: got %b want 0", tx_start_o); else n_pass++;
        n_checks++; if (app_gnt_o !== 1'b0) $display("FAIL rst_gnt: got %b want 0", app_gnt_o); else n_pass++;
        n_checks++; if (tx_type_o !== 4'd0) $display("FAIL rst_type: got %0d want 0", tx_type_o); else n_pass++;
        n_checks++; if (tx_seqnum_o !== 4'd1) $display("FAIL rst_seq: got %0d want 1", tx_seqnum_o); else n_pass++;
        n_checks++; if (session_active_o !== 1'b0) $display("FAIL rst_active: got %b want 0", session_active_o); else n_pass++;
        rst = 1'b0; app_req_i = 1'b0;
    endtask

    task automatic test_logon();
        do_reset();
        auto_done = 1'b1;
        send_rx(3'd3, 4'd8);
        send_rx(3'd6, 4'd8);
        send_rx(3'd0, 4'd4);
        send_rx(3'd4, 4'd8);
        repeat (5) cycle();
        n_checks++; if (st_type.size() != 0) $display("FAIL down_ignore: got %0d starts want 0", st_type.size()); else n_pass++;
        send_rx(3'd0, 4'd1);
        wait_starts(1, 10, "logon");
        n_checks++; if (st_type[0] !== 4'd1) $display("FAIL logon_type: got %0d want 1", st_type[0]); else n_pass++;
        n_checks++; if (st_seq[0] !== 4'd1) $display("FAIL logon_seq: got %0d want 1", st_seq[0]); else n_pass++;
        n_checks++; if (st_gnt[0] !== 1'b0) $display("FAIL logon_gnt: got %b want 0", st_gnt[0]); else n_pass++;
        cycle();
        n_checks++; if (session_active_o !== 1'b1) $display("FAIL logon_active: got %b want 1", session_active_o); else n_pass++;
        n_checks++; if (tx_seqnum_o !== 4'd2) $display("FAIL logon_seq_after: got %0d want 2", tx_seqnum_o); else n_pass++;
    endtask

    task automatic test_heartbeat();
        do_reset();
        auto_done = 1'b1; keepalive = 1'b1;
        send_rx(3'd0, 4'd1);
        wait_starts(4, 60, "heartbeat");
        n_checks++; if (st_cyc[1] - st_cyc[0] != 10) $display("FAIL hb_first_gap: got %0d want 10", st_cyc[1] - st_cyc[0]); else n_pass++;
        for (int i = 2; i < 4; i++) begin
            n_checks++; if (st_cyc[i] - st_cyc[i-1] != 9) $display("FAIL hb_period%0d: got %0d want 9", i, st_cyc[i] - st_cyc[i-1]); else n_pass++;
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (st_type[i] !== 4'd3) $display("FAIL hb_type%0d: got %0d want 3", i, st_type[i]); else n_pass++;
            n_checks++; if (st_seq[i] !== 4'(i + 1)) $display("FAIL hb_seq%0d: got %0d want %0d", i, st_seq[i], i + 1); else n_pass++;
        end
        keepalive = 1'b0;
    endtask

    task automatic test_silent_rx();
        int         exp_off[5] = '{0, 10, 19, 21, 27};
        logic [3:0] exp_typ[5] = '{4'd1, 4'd3, 4'd4, 4'd3, 4'd2};
        do_reset();
        auto_done = 1'b1;
        send_rx(3'd0, 4'd1);
        wait_starts(5, 80, "silent");
        for (int i = 1; i < 5; i++) begin
            n_checks++; if (st_cyc[i] - st_cyc[0] != exp_off[i]) $display("FAIL silent_off%0d: got %0d want %0d", i, st_cyc[i] - st_cyc[0], exp_off[i]); else n_pass++;
            n_checks++; if (st_type[i] !== exp_typ[i]) $display("FAIL silent_type%0d: got %0d want %0d", i, st_type[i], exp_typ[i]); else n_pass++;
        end
        n_checks++; if (st_seq[4] !== 4'd5) $display("FAIL silent_logout_seq: got %0d want 5", st_seq[4]); else n_pass++;
        repeat (20) cycle();
        n_checks++; if (session_active_o !== 1'b0) $display("FAIL silent_down: got %b want 0", session_active_o); else n_pass++;
        n_checks++; if (tx_seqnum_o !== 4'd1) $display("FAIL silent_seq_reset: got %0d want 1", tx_seqnum_o); else n_pass++;
        n_checks++; if (st_type.size() != 5) $display("FAIL silent_quiet: got %0d starts want 5", st_type.size()); else n_pass++;
    endtask

    task automatic test_priority();
        bring_up();
        auto_done = 1'b0; app_req_i = 1'b1;
        wait_starts(1, 5, "prio_app");
        send_rx(3'd6, 4'd0);
        send_rx(3'd3, 4'd0);
        tx_done_i = 1'b1;
        cycle();
        auto_done = 1'b1;
        wait_starts(4, 20, "prio_grants");
        exp_q = '{4'd8, 4'd6, 4'd5, 4'd8};
        for (int i = 0; i < 4; i++) begin
            logic [3:0] e;
            e = exp_q.pop_front();
            n_checks++; if (st_type[i] !== e) $display("FAIL prio_type%0d: got %0d want %0d", i, st_type[i], e); else n_pass++;
            n_checks++; if (st_gnt[i] !== (e == 4'd8)) $display("FAIL prio_gnt%0d: got %b want %b", i, st_gnt[i], e == 4'd8); else n_pass++;
            n_checks++; if (st_seq[i] !== 4'(i + 2)) $display("FAIL prio_seq%0d: got %0d want %0d", i, st_seq[i], i + 2); else n_pass++;
        end
        app_req_i = 1'b0;
    endtask

    task automatic test_err4_logout();
        bring_up();
        auto_done = 1'b0; app_req_i = 1'b1;
        wait_starts(1, 5, "err4_app");
        send_rx(3'd4, 4'd8);
        send_rx(3'd3, 4'd8);
        tx_done_i = 1'b1;
        cycle();
        auto_done = 1'b1;
        repeat (20) cycle();
        n_checks++; if (st_type.size() != 2) $display("FAIL err4_count: got %0d starts want 2", st_type.size()); else n_pass++;
        n_checks++; if (st_type[1] !== 4'd2) $display("FAIL err4_logout_type: got %0d want 2", st_type[1]); else n_pass++;
        n_checks++; if (st_seq[1] !== 4'd3) $display("FAIL err4_logout_seq: got %0d want 3", st_seq[1]); else n_pass++;
        n_checks++; if (gnt_cnt != 1) $display("FAIL err4_app_gnts: got %0d want 1", gnt_cnt); else n_pass++;
        n_checks++; if (session_active_o !== 1'b0) $display("FAIL err4_down: got %b want 0", session_active_o); else n_pass++;
        n_checks++; if (tx_seqnum_o !== 4'd1) $display("FAIL err4_seq: got %0d want 1", tx_seqnum_o); else n_pass++;
        // The reject latched during CLOSING must not survive into the next session.
        app_req_i = 1'b0;
        send_rx(3'd0, 4'd1);
        wait_starts(4, 40, "err4_relogon");
        n_checks++; if (st_type[2] !== 4'd1) $display("FAIL relogon_type: got %0d want 1", st_type[2]); else n_pass++;
        n_checks++; if (st_seq[2] !== 4'd1) $display("FAIL relogon_seq: got %0d want 1", st_seq[2]); else n_pass++;
        n_checks++; if (st_type[3] !== 4'd3) $display("FAIL flags_cleared_type: got %0d want 3", st_type[3]); else n_pass++;
        n_checks++; if (st_cyc[3] - st_cyc[2] != 10) $display("FAIL flags_cleared_gap: got %0d want 10", st_cyc[3] - st_cyc[2]); else n_pass++;
    endtask

    task automatic test_seq_wrap();
        logic [3:0] exp_seq;
        do_reset();
        auto_done = 1'b1; keepalive = 1'b1; app_req_i = 1'b1;
        send_rx(3'd0, 4'd1);
        wait_starts(17, 200, "wrap");
        exp_seq = 4'd1;
        for (int i = 0; i < 17; i++) begin
            n_checks++; if (st_seq[i] !== exp_seq) $display("FAIL wrap_seq%0d: got %0d want %0d", i, st_seq[i], exp_seq); else n_pass++;
            exp_seq = (exp_seq == 4'd15) ? 4'd1 : exp_seq + 4'd1;
        end
        app_req_i = 1'b0; keepalive = 1'b0;
    endtask

    task automatic test_rst_wait();
        do_reset();
        send_rx(3'd0, 4'd1);
        wait_starts(1, 10, "rstwait_logon");
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        n_checks++; if (tx_start_o !== 1'b0) $display("FAIL rstwait_start: got %b want 0", tx_start_o); else n_pass++;
        n_checks++; if (app_gnt_o !== 1'b0) $display("FAIL rstwait_gnt: got %b want 0", app_gnt_o); else n_pass++;
        n_checks++; if (tx_type_o !== 4'd0) $display("FAIL rstwait_type: got %0d want 0", tx_type_o); else n_pass++;
        n_checks++; if (tx_seqnum_o !== 4'd1) $display("FAIL rstwait_seq: got %0d want 1", tx_seqnum_o); else n_pass++;
        tx_done_i = 1'b1;
        repeat (6) cycle();
        n_checks++; if (tx_seqnum_o !== 4'd1) $display("FAIL rstwait_late_done_seq: got %0d want 1", tx_seqnum_o); else n_pass++;
        n_checks++; if (session_active_o !== 1'b0) $display("FAIL rstwait_active: got %b want 0", session_active_o); else n_pass++;
        n_checks++; if (st_type.size() != 1) $display("FAIL rstwait_no_start: got %0d starts want 1", st_type.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_logon();
        test_heartbeat();
        test_silent_rx();
        test_priority();
        test_err4_logout();
        test_seq_wrap();
        test_rst_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
